// File: rtl/tt_seq_pkg.sv
// Shared types and sizes for the truth-table sequencer.
// State encoding, vector count, counter width and a popcount helper.
package tt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int unsigned NVEC  = 8;
    localparam int unsigned XW    = 3;
    localparam int unsigned CNT_W = 4;

    function automatic logic [3:0] popcount8(input logic [NVEC-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NVEC; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_timer.sv
// Settle down-counter: loads a value, counts down while enabled,
// and flags zero. Stops at zero.
module tt_settle_timer
    import tt_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps all 8 input vectors of a 3-input block and captures its table.
// Optional TT_SEQ_ERRCNT_EN adds a saturating mismatch counter err_cnt.
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int unsigned     SETTLE   = 2,
    parameter logic [NVEC-1:0] EXPECTED = 8'hE8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            f,
    output logic [XW-1:0]   x,
    output logic            busy,
    output logic            done,
    output logic [NVEC-1:0] tt,
    output logic [NVEC-1:0] mismatch,
    output logic            pass
`ifdef TT_SEQ_ERRCNT_EN
    ,
    output logic [7:0]      err_cnt
`endif
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

    state_t          state, state_d;
    logic [XW-1:0]   x_d;
    logic [NVEC-1:0] shadow, shadow_d;
    logic [NVEC-1:0] tt_d, mm_d;
    logic            pass_d, done_d;
    logic            load, en, zero;

    tt_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (RELOAD),
        .en       (en),
        .zero     (zero)
    );

    always_comb begin
        state_d  = state;
        x_d      = x;
        shadow_d = shadow;
        tt_d     = tt;
        mm_d     = mismatch;
        pass_d   = pass;
        done_d   = 1'b0;
        load     = 1'b0;
        en       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_d  = ST_DRIVE;
                    x_d      = '0;
                    shadow_d = '0;
                    load     = 1'b1;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    x_d     = '0;
                end else if (zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    x_d     = '0;
                end else begin
                    shadow_d[x] = f;
                    if (x == XW'(NVEC - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRIVE;
                        x_d     = x + 1'b1;
                        load    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // Publish is unconditional: abort is not honoured here
                tt_d    = shadow;
                mm_d    = shadow ^ EXPECTED;
                pass_d  = (shadow == EXPECTED);
                done_d  = 1'b1;
                state_d = ST_IDLE;
                x_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            x        <= '0;
            shadow   <= '0;
            tt       <= '0;
            mismatch <= '0;
            pass     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            x        <= x_d;
            shadow   <= shadow_d;
            tt       <= tt_d;
            mismatch <= mm_d;
            pass     <= pass_d;
            done     <= done_d;
        end
    end

    assign busy = (state != ST_IDLE);

`ifdef TT_SEQ_ERRCNT_EN
    logic [8:0] err_sum;

    assign err_sum = {1'b0, err_cnt} + {5'b00000, popcount8(shadow ^ EXPECTED)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (state == ST_DONE) begin
            err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
        end
    end
`endif

endmodule
